// File: rtl/fetch_ctrl.sv
// fetch_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for a simple
// load/store core. Holds the instruction register, latches the ALU zero flag
// for branches and issues the PC-advance strobe to the fetch unit.
// Optional feature macro: ACK_TIMEOUT_EN adds an 8-bit ack watchdog that
// aborts a stuck FETCH/MEM into WB and raises a sticky err flag.
module fetch_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_ack,
   input  logic [31:0] instr,
   input  logic        alu_zero,
   input  logic        dmem_ack,
   input  logic        stall,
   output logic        imem_req,
   output logic        dmem_req,
   output logic [31:0] ir,
   output logic        pc_en,
   output logic        branch,
   output logic        zero_q,
   output logic        rf_we,
   output logic [2:0]  state,
   output logic        err
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2b;

   state_t      r_state;
   logic [31:0] r_ir;
   logic        r_zero_q;

   logic [5:0]  w_opcode;
   logic        w_is_beq;
   logic        w_is_sw;
   logic        w_is_mem;
   logic        w_abort;

   assign w_opcode = r_ir[31:26];
   assign w_is_beq = (w_opcode == OP_BEQ);
   assign w_is_sw  = (w_opcode == OP_SW);
   assign w_is_mem = (w_opcode == OP_LW) || w_is_sw;

   assign ir     = r_ir;
   assign zero_q = r_zero_q;
   assign state  = r_state;

`ifdef ACK_TIMEOUT_EN
   logic [7:0] r_wait_cnt;
   logic       r_err;
   logic       r_abort;
   logic       w_waiting;
   logic       w_timeout;

   // A cycle counts as waiting only in FETCH/MEM with the matching ack low.
   assign w_waiting = ((r_state == S_FETCH) && !imem_ack) ||
                      ((r_state == S_MEM)   && !dmem_ack);
   assign w_timeout = w_waiting && (r_wait_cnt == 8'd255);
   assign w_abort   = r_abort;
   assign err       = r_err;

   // Wait counter: increments while waiting, cleared whenever the state moves.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt <= 8'd0;
      end else if (w_waiting && !w_timeout) begin
         r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
         r_wait_cnt <= 8'd0;
      end
   end
`else
   assign w_abort = 1'b0;
   assign err     = 1'b0;
`endif

   // Sequencer: state transitions, instruction register and zero-flag latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_FETCH;
         r_ir     <= 32'd0;
         r_zero_q <= 1'b0;
`ifdef ACK_TIMEOUT_EN
         r_err    <= 1'b0;
         r_abort  <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_FETCH: begin
               if (imem_ack) begin
                  r_ir    <= instr;
                  r_state <= S_DECODE;
               end
`ifdef ACK_TIMEOUT_EN
               else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_abort <= 1'b1;
                  r_state <= S_WB;
               end
`endif
            end
            S_DECODE: r_state <= S_EXEC;
            S_EXEC: begin
               if (w_is_beq) begin
                  r_zero_q <= alu_zero;
               end
               r_state <= w_is_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
               if (dmem_ack) begin
                  r_state <= S_WB;
               end
`ifdef ACK_TIMEOUT_EN
               else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_abort <= 1'b1;
                  r_state <= S_WB;
               end
`endif
            end
            S_WB: begin
               if (!stall) begin
`ifdef ACK_TIMEOUT_EN
                  r_abort <= 1'b0;
`endif
                  r_state <= S_FETCH;
               end
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end

   // Output decode from state, ir and stall; everything held low during reset.
   always_comb begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      pc_en    = 1'b0;
      branch   = 1'b0;
      rf_we    = 1'b0;
      if (!rst) begin
         case (r_state)
            S_FETCH: imem_req = 1'b1;
            S_MEM:   dmem_req = 1'b1;
            S_WB: begin
               if (!stall) begin
                  pc_en  = 1'b1;
                  branch = w_is_beq && !w_abort;
                  rf_we  = !w_is_beq && !w_is_sw && !w_abort;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL provide the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_ack  in  1  instruction memory data valid.
- instr  in  32  instruction word, sampled when imem_ack=1 in FETCH.
- alu_zero  in  1  ALU zero flag, sampled in EXEC.
- dmem_ack  in  1  data memory transfer complete.
- stall  in  1  hazard hold request, honoured in WB only.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- ir  out  32  instruction register.
- pc_en  out  1  one-cycle PC advance strobe to the fetch unit.
- branch  out  1  branch select to the fetch unit's b input.
- zero_q  out  1  latched zero flag to the fetch unit's z input.
- rf_we  out  1  register file write enable.
- state  out  3  current state encoding.
- err  out  1  sticky timeout flag; constant 0 unless ACK_TIMEOUT_EN is defined.

Function
REQ-002 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM=3 and WB=4; encodings 5-7 SHALL go to FETCH on the next edge.
REQ-003 In FETCH, SHALL drive imem_req=1; on imem_ack=1, SHALL load ir<=instr and go to DECODE; otherwise SHALL hold FETCH.
REQ-004 DECODE SHALL go to EXEC unconditionally after one cycle.
REQ-005 Opcode is ir[31:26]: 6'h04 = beq, 6'h23 = lw, 6'h2b = sw; every other opcode is treated as an ALU op.
REQ-006 In EXEC:
- zero_q SHALL load alu_zero if the opcode is beq; otherwise zero_q holds.
- lw/sw SHALL go to MEM; all other opcodes SHALL go to WB.
REQ-007 In MEM, SHALL drive dmem_req=1; on dmem_ack=1, SHALL go to WB; otherwise SHALL hold MEM.
REQ-008 In WB with stall=0:
- pc_en=1 for exactly that cycle.
- branch=1 if the opcode is beq, else 0.
- rf_we=1 for ALU ops and lw; 0 for sw and beq.
- next state is FETCH.
REQ-009 In WB with stall=1, SHALL drive pc_en=0, rf_we=0 and branch=0, and SHALL hold WB.
REQ-010 Outside WB, pc_en, rf_we and branch SHALL be 0. imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-011 imem_req, dmem_req, pc_en, branch and rf_we SHALL be combinational decodes of the state, ir and stall, gated low while rst=1. ir, zero_q, state and err SHALL be registered.
REQ-012 Minimum latency from entering FETCH to the pc_en strobe SHALL be 4 cycles for ALU/beq and 5 cycles for lw/sw, with single-cycle acks.
REQ-013 A new fetch SHALL start in the cycle after the pc_en strobe, with no idle cycle.

Reset
REQ-014 rst=1 at a clock edge SHALL force state=FETCH, ir=0, zero_q=0 and err=0, from any state and mid-transfer. rst SHALL take priority over ack, stall and timeout.
REQ-015 While rst=1, all combinational outputs SHALL be 0. imem_req SHALL rise in the first cycle after rst falls.

Configuration
REQ-016 Macro ACK_TIMEOUT_EN, when defined, SHALL add an 8-bit wait counter with the following behaviour:
- Counter clears on every state change and counts each cycle spent in FETCH or MEM without the matching ack.
- On reaching 255, the next edge SHALL set err=1 (sticky until rst) and SHALL go to WB with the transfer aborted.
- In that WB: pc_en=1, branch=0, rf_we=0, so the instruction is skipped.
REQ-017 Without ACK_TIMEOUT_EN, no counter SHALL exist, err SHALL be tied to 0, and FETCH/MEM SHALL wait indefinitely.

Verification
REQ-018 Reset, then an ALU instr 32'h00221820 with imem_ack held at 1 -> state sequence 0,1,2,4,0; pc_en=1 and rf_we=1 in the 4th cycle; branch=0.
REQ-019 beq 32'h10220003 with alu_zero=1 in EXEC -> zero_q=1 and branch=1 with pc_en=1 in WB, rf_we=0. Repeat with alu_zero=0 -> zero_q=0, branch=1.
REQ-020 lw 32'h8C410004 with dmem_ack delayed 3 cycles -> dmem_req=1 for 4 cycles, then WB with rf_we=1; sw 32'hAC410004 -> WB with rf_we=0.
REQ-021 stall=1 for 2 cycles on entering WB -> WB held 3 cycles total; pc_en=1 only in the 3rd cycle; rst=1 asserted in MEM -> state=0, ir=0 on the next edge.
REQ-022 With ACK_TIMEOUT_EN defined and imem_ack held at 0 -> err=1 after 256 cycles in FETCH, one WB cycle with pc_en=1 and branch=0, then FETCH; err stays 1 until rst.
